// File: rtl/axis_upsizer_if.sv
// Narrow-in / wide-out stream bundle for axis_upsizer.
// Optional tlast/tkeep side-band exists only when UPSIZER_TLAST_EN is defined.
interface axis_upsizer_if #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned RATIO      = 4
);
  logic                        tvalid_i;
  logic                        tready_o;
  logic [DATA_WIDTH-1:0]       tdata_i;
  logic                        tvalid_o;
  logic                        tready_i;
  logic [DATA_WIDTH*RATIO-1:0] tdata_o;
`ifdef UPSIZER_TLAST_EN
  logic                        tlast_i;
  logic                        tlast_o;
  logic [RATIO-1:0]            tkeep_o;
`endif

  modport slave (
    input  tvalid_i, tdata_i, tready_i,
`ifdef UPSIZER_TLAST_EN
    input  tlast_i,
    output tlast_o, tkeep_o,
`endif
    output tready_o, tvalid_o, tdata_o
  );

  modport master (
    output tvalid_i, tdata_i, tready_i,
`ifdef UPSIZER_TLAST_EN
    output tlast_i,
    input  tlast_o, tkeep_o,
`endif
    input  tready_o, tvalid_o, tdata_o
  );
endinterface

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow beats (little-endian lanes) into one registered wide beat.
// Define UPSIZER_TLAST_EN to add tlast_i/tlast_o/tkeep_o and early word completion.
module axis_upsizer #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned RATIO      = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  axis_upsizer_if.slave bus
);
  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic {FILL, LAST_LANE} lane_state_t;

  lane_state_t                  lane_st;
  logic [CW-1:0]                cnt;
  logic [DATA_WIDTH*(RATIO-1)-1:0] acc;
  logic [DATA_WIDTH*RATIO-1:0]  data_q;
  logic                         valid_q;
  logic                         ready;
  logic                         accept;
  logic                         complete;
  logic                         ends_word;
  logic [DATA_WIDTH*RATIO-1:0]  word;
  logic [RATIO-1:0]             keep;
`ifdef UPSIZER_TLAST_EN
  logic                         last_q;
  logic [RATIO-1:0]             keep_q;
`endif

  always_comb begin
    lane_st = (cnt == LAST) ? LAST_LANE : FILL;
`ifdef UPSIZER_TLAST_EN
    ends_word = (lane_st == LAST_LANE) || bus.tlast_i;
`else
    ends_word = (lane_st == LAST_LANE);
`endif
    ready    = !rst_i && !(ends_word && valid_q && !bus.tready_i);
    accept   = bus.tvalid_i && ready;
    complete = accept && ends_word;
  end

  // Lanes below cnt come from acc, lane cnt is the incoming beat, lanes above
  // are zero; on a full word this reduces to {tdata_i, acc}.
  always_comb begin
    word = '0;
    keep = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (CW'(k) < cnt) begin
        word[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
        keep[k] = 1'b1;
      end else if (CW'(k) == cnt) begin
        word[k*DATA_WIDTH +: DATA_WIDTH] = bus.tdata_i;
        keep[k] = 1'b1;
      end
    end
    if (cnt == LAST) begin
      word[(RATIO-1)*DATA_WIDTH +: DATA_WIDTH] = bus.tdata_i;
      keep[RATIO-1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      acc     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef UPSIZER_TLAST_EN
      last_q  <= 1'b0;
      keep_q  <= '0;
`endif
    end else begin
      if (accept && !complete) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (cnt == CW'(k)) acc[k*DATA_WIDTH +: DATA_WIDTH] <= bus.tdata_i;
        end
        cnt <= cnt + 1'b1;
      end
      if (complete) begin
        cnt     <= '0;
        data_q  <= word;
        valid_q <= 1'b1;
`ifdef UPSIZER_TLAST_EN
        last_q  <= bus.tlast_i;
        keep_q  <= keep;
`endif
      end else if (valid_q && bus.tready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.tready_o = ready;
  assign bus.tvalid_o = valid_q;
  assign bus.tdata_o  = data_q;
`ifdef UPSIZER_TLAST_EN
  assign bus.tlast_o  = last_q;
  assign bus.tkeep_o  = keep_q;
`endif
endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

Stream width upsizer that packs RATIO consecutive narrow beats of DATA_WIDTH bits into one wide beat of DATA_WIDTH*RATIO bits. It sits directly downstream of the register-slice buffer and consumes its tvalid/tready/tdata output. It feeds wide-datapath consumers at the same clock rate. It sustains one narrow beat per cycle with no bubbles while the downstream side keeps up.

## Interface
- DATA_WIDTH, default 3: narrow (input) beat width in bits, ≥1.
- RATIO, default 4: narrow beats per wide beat, ≥2.
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- tvalid_i  in  1  narrow beat valid.
- tready_o  out  1  narrow beat accepted when tvalid_i && tready_o.
- tdata_i  in  DATA_WIDTH  narrow beat payload.
- tvalid_o  out  1  wide beat valid (registered).
- tready_i  in  1  downstream ready.
- tdata_o  out  DATA_WIDTH*RATIO  wide beat payload (registered).
- (UPSIZER_TLAST_EN only) tlast_i  in  1 / tlast_o  out  1 / tkeep_o  out  RATIO, one bit per lane.

## Operation
- Internal: lane counter cnt (clog2(RATIO) bits, 0..RATIO-1), assembly register acc (DATA_WIDTH*(RATIO-1) bits for lanes 0..RATIO-2), output register tdata_o/tvalid_o.
- Lane order little-endian: first accepted beat → tdata_o[DATA_WIDTH-1:0], k-th → bits [k*DATA_WIDTH +: DATA_WIDTH].
- States by cnt and tvalid_o: FILL (cnt<RATIO-1), LAST_LANE (cnt==RATIO-1), plus output-hold flag tvalid_o independent of cnt.
- Accept with cnt<RATIO-1: store tdata_i in acc lane cnt, cnt←cnt+1.
- Accept with cnt==RATIO-1: tdata_o←{tdata_i, acc}, tvalid_o←1, cnt←0.
- tready_o = !rst_i && !(cnt==RATIO-1 && tvalid_o && !tready_i). It is combinational from tready_i, by design. FILL lanes are always accepted while the previous wide beat waits.
- Output handshake (tvalid_o && tready_i) without a simultaneous completing accept: tvalid_o←0. A simultaneous completing accept wins: tvalid_o stays 1 and tdata_o is loaded with the new word.
- tdata_o and tvalid_o hold stable while tvalid_o && !tready_i.
- Reset (any cycle, including mid-word): cnt←0, acc←0, tvalid_o←0, tdata_o←0. Partial lanes are discarded. tready_o is 0 during the reset cycle and 1 the cycle after.

## Timing
- Latency: tvalid_o rises the cycle after the RATIO-th lane handshake.
- Throughput: 1 narrow beat/cycle sustained, 1 wide beat per RATIO cycles, with tready_i held high or toggling at ≤ 1/RATIO duty loss.
- Backpressure reaches upstream only on the completing lane: at most RATIO-1 beats are absorbed while tvalid_o is stalled.
- No combinational path from tvalid_i or tdata_i to any output.

## Configuration
- UPSIZER_TLAST_EN defined:
  - A tlast_i accept in lane k<RATIO-1 completes the word early: lanes >k are zeroed, tkeep_o = (1<<(k+1))-1, tlast_o=1, cnt←0.
  - A tlast_i accept in lane RATIO-1 gives a full tkeep_o with tlast_o=1.
  - Without tlast_i, tkeep_o is all-ones and tlast_o=0.
  - The tready_o stall condition becomes (cnt==RATIO-1 || tlast_i) && tvalid_o && !tready_i.
  - Reset values: tlast_o=0, tkeep_o=0.
- Not defined: tlast_i, tlast_o and tkeep_o ports are absent. Words complete only on the RATIO-th lane.

## Test plan
- DATA_WIDTH=8, RATIO=4, tready_i=1, inputs 0x11,0x22,0x33,0x44 back-to-back → tdata_o=0x44332211, tvalid_o high exactly one cycle, one cycle after the 0x44 accept.
- Continuous stream 0x00..0x0F with tready_i=1 → four wide beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; tready_o never low.
- Word 0x44332211 pending with tready_i=0, inputs 0x55,0x66,0x77 accepted, 0x88 presented → tready_o=0 until tready_i=1. Then 0x88 is accepted in the same cycle as the output handshake, and tdata_o=0x88776655 follows with tvalid_o continuously high.
- rst_i asserted for 1 cycle after 0xAA,0xBB accepted, then 0x01..0x04 → single output 0x04030201; the partial lanes never appear on tdata_o.
- UPSIZER_TLAST_EN: 0xA1, then 0xB2 with tlast_i=1 → tdata_o=0x0000B2A1, tkeep_o=4'b0011, tlast_o=1. The next four beats produce tkeep_o=4'b1111, tlast_o=0.
- Reset release: tvalid_o=0, tdata_o=0, tready_o=0 during rst_i and =1 on the first cycle after.
